// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter granting one shared select resource; the registered owner index
// is decoded to a one-hot grant. Optional hold watchdog enabled by `define ARB_TIMEOUT_EN.
module rr_decode_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [IDX_W-1:0] winner;
  logic             owner_release;
  logic             expire;

  // Scan from ptr downwards in priority so the nearest requester at or after ptr wins.
  always_comb begin
    winner = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[ptr_q + IDX_W'(k)]) begin
        winner = ptr_q + IDX_W'(k);
      end
    end
  end

  assign owner_release = done[gnt_idx_q] | ~req[gnt_idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign expire = (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE) begin
      hold_cnt_d = '0;
    end else if (state_q == BUSY) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_max_hold;

  assign expire          = 1'b0;
  assign unused_max_hold = |MAX_HOLD;
`endif

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = BUSY;
          gnt_idx_d   = winner;
          gnt_valid_d = 1'b1;
        end
      end
      BUSY: begin
        // A genuine release on the expiry edge wins over the watchdog.
        if (owner_release || expire) begin
          state_d     = GAP;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + 1'b1;
          timeout_d   = ~owner_release;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    gnt = '0;
    for (int i = 0; i < N; i++) begin
      gnt[i] = gnt_valid_q && (gnt_idx_q == IDX_W'(i));
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: doc/rr_decode_arbiter.md
# rr_decode_arbiter

Round-robin arbiter that shares one decoded select resource among N requesters. It picks a winner, registers the winner's binary index, and drives it through a behavioural index-to-one-hot decoder as the grant vector. The grant is held until the owner releases it, and a fixed turnaround cycle follows every release. It sits between the requesting blocks and the shared bus or select lines that the decoder enables.

## Interface
- N, 8, number of requesters; power of two, 2..64
- IDX_W, $clog2(N), width of the grant index
- MAX_HOLD, 16, maximum cycles a grant may be held (used only with ARB_TIMEOUT_EN)

- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  N  request per requester; level, held until granted and done
- done  in  N  release strobe per requester; only done[gnt_idx] is honoured, only in BUSY
- gnt  out  N  one-hot grant; all zero when gnt_valid=0
- gnt_idx  out  IDX_W  binary index of current/last owner
- gnt_valid  out  1  a grant is active
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog

## Operation
- Reset values: state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, gnt=0, timeout=0, hold counter=0.
- Registered state: ptr (IDX_W), gnt_idx, FSM state, and a hold counter when timeout is enabled.
- gnt is purely combinational from registered gnt_idx and gnt_valid: gnt = gnt_valid ? (1 << gnt_idx) : 0. No other path drives gnt.
- FSM states:
  - IDLE: if req != 0, winner = first i scanning ptr, ptr+1, …, ptr+N-1 (mod N) with req[i]=1. Next state BUSY, gnt_idx<=winner, gnt_valid<=1. If req == 0, stay in IDLE.
  - BUSY: exit when done[gnt_idx]=1 or req[gnt_idx]=0 (requester withdrew). On exit: next state GAP, gnt_valid<=0, ptr<=gnt_idx+1 mod N (wraps N-1 -> 0). Otherwise hold.
  - GAP: one idle turnaround cycle with gnt=0. Next state IDLE unconditionally; requests are not evaluated here.
- done on non-owner bits, or in IDLE or GAP, is ignored.
- Simultaneous done[gnt_idx] and watchdog expiry: treat as a normal release, no timeout pulse.
- A requester may re-request immediately after release; it gets lowest priority next round because ptr has moved past it.
- rst asserted in any state, including mid-grant: next edge forces the reset values; gnt drops in the following cycle.

## Timing
- Grant latency: req sampled at edge k in IDLE -> gnt valid during cycle k+1.
- Release: done sampled at edge m -> gnt=0 from cycle m+1 (GAP). Earliest new grant is cycle m+3 (GAP at m+1, IDLE at m+2, grant at m+3).
- Minimum grant duration: 1 cycle. Back-to-back grant period: grant cycles + 2.
- Fairness: with all N requesting continuously and releasing after 1 cycle, each requester is granted exactly once every N grants.

## Configuration
- ARB_TIMEOUT_EN defined:
  - The hold counter clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD-1 with no release, the FSM goes to GAP, gnt_valid<=0, and ptr advances as for a normal release.
  - timeout=1 during that GAP cycle only.
- Not defined: no counter is built, timeout is tied to 0, and a grant holds indefinitely.

## Test plan
- Reset: assert rst 2 cycles with req=8'hFF -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout and one cycle after deassert.
- Single requester: req=8'h08 at edge 0 -> gnt=8'h08, gnt_idx=3 from cycle 1. done[3] at edge 4 -> gnt=0 cycles 5–6. Keep req[3] high -> gnt=8'h08 again at cycle 7.
- Round-robin wrap: req=8'h81 constant, 1-cycle holds -> grant sequence idx 0, 7, 0, 7. Then ptr=7 with req=8'h81 -> idx 7 first, then 0.
- Ignored done: owner idx 2, done=8'h10 pulse -> grant unchanged. done while gnt_valid=0 -> no state change.
- Withdraw and reset mid-grant: owner idx 5 drops req[5] -> GAP next cycle, ptr=6. rst during BUSY -> next cycle gnt=0, ptr=0.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): idx 1 never releases -> gnt high exactly 4 cycles, timeout pulses 1 cycle, next grant goes to idx 2 if requesting. Done and expiry on the same edge -> timeout stays 0.
